psum_drain_scheduler: RTL and testbench

//  Sequences draining of PE-array partial sums (one psum_rf slice = ROW*COL*DATA_BITWIDTH bits) into the

---
 rtl/psum_drain_scheduler_if.sv | 34 +++
 rtl/psum_drain_scheduler.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_psum_drain_scheduler.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_drain_scheduler_if.sv
// Write bus into the double-buffered psum_gbf plus the per-bank full/release handshake.
// The scheduler is the master: it drives the write bus and the full flags, and the consumer returns releases.
interface psum_drain_scheduler_if #(
    parameter int GBF_DATA_BITWIDTH = 512,
    parameter int GBF_ADDR_BITWIDTH = 5
);
    logic [GBF_DATA_BITWIDTH-1:0] out_data;
    logic                         psum_gbf_w_en;
    logic [GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr;
    logic                         psum_gbf_w_acc;
    logic                         psum_gbf_w_num;
    logic [1:0]                   buf_full;
    logic [1:0]                   buf_release;

    modport master (
        output out_data,
        output psum_gbf_w_en,
        output psum_gbf_w_addr,
        output psum_gbf_w_acc,
        output psum_gbf_w_num,
        output buf_full,
        input  buf_release
    );

    modport slave (
        input  out_data,
        input  psum_gbf_w_en,
        input  psum_gbf_w_addr,
        input  psum_gbf_w_acc,
        input  psum_gbf_w_num,
        input  buf_full,
        output buf_release
    );
endinterface

// File: rtl/psum_drain_scheduler.sv
// Drains PE-array psum_rf slices into the ping-pong psum_gbf in wide beats (MSB beat first),
// choosing overwrite vs accumulate per pass and handing full banks to the consumer.
module psum_drain_scheduler #(
    parameter int ROW                   = 16,
    parameter int COL                   = 16,
    parameter int DATA_BITWIDTH         = 16,
    parameter int GBF_DATA_BITWIDTH     = 512,
    parameter int PSUM_RF_ADDR_BITWIDTH = 2,
    parameter int GBF_ADDR_BITWIDTH     = 5,
    parameter int CNT_BITWIDTH          = 8
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               cfg_load,
    input  logic [PSUM_RF_ADDR_BITWIDTH:0]     cfg_rel_num,
    input  logic [CNT_BITWIDTH-1:0]            cfg_irrel_num,
    input  logic                               pe_psum_finish,
    input  logic                               conv_finish,
    input  logic [DATA_BITWIDTH*ROW*COL-1:0]   psum_out,
    output logic [PSUM_RF_ADDR_BITWIDTH-1:0]   psum_rf_addr,
    output logic                               su_add_finish,
    output logic                               busy,
    output logic                               done,
    output logic                               err_overrun,
    psum_drain_scheduler_if.master             gbf
);

    localparam int PSUM_W        = DATA_BITWIDTH * ROW * COL;
    localparam int BEATS         = PSUM_W / GBF_DATA_BITWIDTH;
    localparam int BEAT_BITWIDTH = $clog2(BEATS);
    localparam int PSUM_IDX_W    = $clog2(PSUM_W);
    localparam int REL_W         = PSUM_RF_ADDR_BITWIDTH + 1;
    localparam int RF_DEPTH      = 1 << PSUM_RF_ADDR_BITWIDTH;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BUF = 3'd1,
        ST_FETCH    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t                             state_r, state_s;
    logic [PSUM_RF_ADDR_BITWIDTH-1:0]   rel_cnt_r;
    logic [BEAT_BITWIDTH-1:0]           beat_r;
    logic [CNT_BITWIDTH-1:0]            irrel_cnt_r;
    logic                               w_num_r;
    logic [1:0]                         buf_full_r;
    logic                               pend_end_r;
    logic                               conv_pend_r;
    logic [REL_W-1:0]                   cfg_rel_r;
    logic [CNT_BITWIDTH-1:0]            cfg_irrel_r;

    logic [PSUM_RF_ADDR_BITWIDTH-1:0]   psum_rf_addr_r, psum_rf_addr_s;
    logic [GBF_DATA_BITWIDTH-1:0]       out_data_r, out_data_s;
    logic                               w_en_r, w_en_s;
    logic [GBF_ADDR_BITWIDTH-1:0]       w_addr_r, w_addr_s;
    logic                               w_acc_r, w_acc_s;
    logic                               su_add_finish_r, su_add_finish_s;
    logic                               busy_r, busy_s;
    logic                               done_r, done_s;
    logic                               err_r, err_s;

    logic                               bank_full_s;
    logic                               idle_free_s;
    logic                               last_beat_s;
    logic                               last_slice_s;
    logic                               last_pass_s;
    logic                               flush_s;
    logic [1:0]                         bank_set_s;
    logic [PSUM_IDX_W-1:0]              beat_lsb_s;

    function automatic logic [REL_W-1:0] clamp_rel(input logic [REL_W-1:0] v);
        if (v == '0) begin
            clamp_rel = REL_W'(1);
        end else if (v > REL_W'(RF_DEPTH)) begin
            clamp_rel = REL_W'(RF_DEPTH);
        end else begin
            clamp_rel = v;
        end
    endfunction

    function automatic logic [CNT_BITWIDTH-1:0] clamp_irrel(input logic [CNT_BITWIDTH-1:0] v);
        if (v == '0) begin
            clamp_irrel = CNT_BITWIDTH'(1);
        end else begin
            clamp_irrel = v;
        end
    endfunction

    // A release arriving this cycle already frees the bank for a start decision.
    assign bank_full_s  = buf_full_r[w_num_r] & ~gbf.buf_release[w_num_r];
    // busy_r stays high through the event-end cycle, which keeps IDLE from starting early.
    assign idle_free_s  = (state_r == ST_IDLE) && !busy_r;
    assign last_beat_s  = (beat_r == BEAT_BITWIDTH'(BEATS - 1));
    assign last_slice_s = ({1'b0, rel_cnt_r} == (cfg_rel_r - REL_W'(1)));
    assign last_pass_s  = (irrel_cnt_r == (cfg_irrel_r - CNT_BITWIDTH'(1)));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; conv_finish outranks a new event in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (idle_free_s && (conv_finish || conv_pend_r)) begin
                    state_s = ST_DONE;
                end else if (idle_free_s && pe_psum_finish) begin
                    state_s = bank_full_s ? ST_WAIT_BUF : ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_BUF: begin
                if (!bank_full_s) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_WAIT_BUF;
                end
            end
            ST_FETCH: state_s = ST_DRAIN;
            ST_DRAIN: begin
                if (last_beat_s) begin
                    state_s = last_slice_s ? ST_IDLE : ST_FETCH;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_DONE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode: next values for every registered output.
    always_comb begin
        // BEATS is a power of two, so (BEATS-1-beat) is just the inverted beat index.
        beat_lsb_s      = PSUM_IDX_W'(~beat_r) << $clog2(GBF_DATA_BITWIDTH);
        w_en_s          = 1'b0;
        out_data_s      = out_data_r;
        w_addr_s        = w_addr_r;
        w_acc_s         = w_acc_r;
        psum_rf_addr_s  = psum_rf_addr_r;
        busy_s          = busy_r;
        su_add_finish_s = pend_end_r;
        done_s          = done_r | (state_s == ST_DONE);
        err_s           = err_r | (pe_psum_finish & busy_r);

        if (state_r == ST_DRAIN) begin
            w_en_s     = 1'b1;
            out_data_s = psum_out[beat_lsb_s +: GBF_DATA_BITWIDTH];
            w_addr_s   = {rel_cnt_r, beat_r};
            w_acc_s    = (irrel_cnt_r != '0);
        end else begin
            w_en_s     = 1'b0;
        end

        // Address moves on FETCH entry so the RF read latency hides inside the bubble.
        if (state_s == ST_FETCH) begin
            if (state_r == ST_DRAIN) begin
                psum_rf_addr_s = rel_cnt_r + PSUM_RF_ADDR_BITWIDTH'(1);
            end else begin
                psum_rf_addr_s = rel_cnt_r;
            end
        end else begin
            psum_rf_addr_s = psum_rf_addr_r;
        end

        if ((state_r == ST_IDLE) && ((state_s == ST_FETCH) || (state_s == ST_WAIT_BUF))) begin
            busy_s = 1'b1;
        end else if (pend_end_r) begin
            busy_s = 1'b0;
        end else begin
            busy_s = busy_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psum_rf_addr_r  <= '0;
            out_data_r      <= '0;
            w_en_r          <= 1'b0;
            w_addr_r        <= '0;
            w_acc_r         <= 1'b0;
            su_add_finish_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            err_r           <= 1'b0;
        end else begin
            psum_rf_addr_r  <= psum_rf_addr_s;
            out_data_r      <= out_data_s;
            w_en_r          <= w_en_s;
            w_addr_r        <= w_addr_s;
            w_acc_r         <= w_acc_s;
            su_add_finish_r <= su_add_finish_s;
            busy_r          <= busy_s;
            done_r          <= done_s;
            err_r           <= err_s;
        end
    end

    // Bank hand-off: at a completed pass group, or at layer end with a partially filled bank.
    always_comb begin
        flush_s    = 1'b0;
        bank_set_s = 2'b00;
        if (pend_end_r) begin
            flush_s = last_pass_s;
        end else if ((state_r != ST_DONE) && (state_s == ST_DONE)) begin
            flush_s = (irrel_cnt_r != '0);
        end else begin
            flush_s = 1'b0;
        end
        if (flush_s) begin
            bank_set_s[w_num_r] = 1'b1;
        end else begin
            bank_set_s = 2'b00;
        end
    end

    // Counters, bank pointer, full flags and layer configuration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rel_cnt_r   <= '0;
            beat_r      <= '0;
            irrel_cnt_r <= '0;
            w_num_r     <= 1'b0;
            buf_full_r  <= 2'b00;
            pend_end_r  <= 1'b0;
            conv_pend_r <= 1'b0;
            cfg_rel_r   <= REL_W'(1);
            cfg_irrel_r <= CNT_BITWIDTH'(1);
        end else begin
            if (cfg_load && idle_free_s && (irrel_cnt_r == '0)) begin
                cfg_rel_r   <= clamp_rel(cfg_rel_num);
                cfg_irrel_r <= clamp_irrel(cfg_irrel_num);
            end else begin
                cfg_rel_r   <= cfg_rel_r;
                cfg_irrel_r <= cfg_irrel_r;
            end

            if ((state_r == ST_DRAIN) && !last_beat_s) begin
                beat_r <= beat_r + BEAT_BITWIDTH'(1);
            end else begin
                beat_r <= '0;
            end

            if ((state_r == ST_DRAIN) && last_beat_s && !last_slice_s) begin
                rel_cnt_r <= rel_cnt_r + PSUM_RF_ADDR_BITWIDTH'(1);
            end else if (pend_end_r) begin
                rel_cnt_r <= '0;
            end else begin
                rel_cnt_r <= rel_cnt_r;
            end

            if (flush_s) begin
                irrel_cnt_r <= '0;
            end else if (pend_end_r) begin
                irrel_cnt_r <= irrel_cnt_r + CNT_BITWIDTH'(1);
            end else begin
                irrel_cnt_r <= irrel_cnt_r;
            end

            pend_end_r  <= (state_r == ST_DRAIN) && last_beat_s && last_slice_s;
            conv_pend_r <= conv_pend_r | conv_finish;
            w_num_r     <= flush_s ? ~w_num_r : w_num_r;
            // Set is applied after release, so a simultaneous release cannot empty a bank being filled.
            buf_full_r  <= (buf_full_r & ~gbf.buf_release) | bank_set_s;
        end
    end

    assign psum_rf_addr        = psum_rf_addr_r;
    assign su_add_finish       = su_add_finish_r;
    assign busy                = busy_r;
    assign done                = done_r;
    assign err_overrun         = err_r;
    assign gbf.out_data        = out_data_r;
    assign gbf.psum_gbf_w_en   = w_en_r;
    assign gbf.psum_gbf_w_addr = w_addr_r;
    assign gbf.psum_gbf_w_acc  = w_acc_r;
    assign gbf.psum_gbf_w_num  = w_num_r;
    assign gbf.buf_full        = buf_full_r;

endmodule

// File: tb/tb_psum_drain_scheduler.sv
// Directed bench for psum_drain_scheduler: a registered psum_rf model feeds known slice patterns,
// and every beat, bubble, event end and bank flag is checked at a fixed cycle.
module tb_psum_drain_scheduler;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_load;
    logic [2:0]    cfg_rel_num;
    logic [7:0]    cfg_irrel_num;
    logic          pe_psum_finish;
    logic          conv_finish;
    logic [4095:0] psum_out;
    logic [1:0]    psum_rf_addr;
    logic          su_add_finish;
    logic          busy;
    logic          done;
    logic          err_overrun;

    int total = 0;
    int bad   = 0;

    psum_drain_scheduler_if #(.GBF_DATA_BITWIDTH(512), .GBF_ADDR_BITWIDTH(5)) gbf_bus ();

    psum_drain_scheduler dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_load       (cfg_load),
        .cfg_rel_num    (cfg_rel_num),
        .cfg_irrel_num  (cfg_irrel_num),
        .pe_psum_finish (pe_psum_finish),
        .conv_finish    (conv_finish),
        .psum_out       (psum_out),
        .psum_rf_addr   (psum_rf_addr),
        .su_add_finish  (su_add_finish),
        .busy           (busy),
        .done           (done),
        .err_overrun    (err_overrun),
        .gbf            (gbf_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] chunk(input int s, input int k);
        logic [31:0] w;
        w = {8'(s), 8'(k), 16'hC3A5 ^ 16'(s * 16 + k)};
        chunk = {16{w}};
    endfunction

    function automatic logic [4095:0] slice_of(input int s);
        logic [4095:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) begin
            v[4095 - k * 512 -: 512] = chunk(s, k);
        end
        slice_of = v;
    endfunction

    // psum_rf with one cycle of read latency
    always @(posedge clk) psum_out <= slice_of(int'(psum_rf_addr));

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        pe_psum_finish = 1'b1;
        step();
        pe_psum_finish = 1'b0;
    endtask

    task automatic load_cfg(input logic [2:0] rel, input logic [7:0] irrel);
        cfg_rel_num   = rel;
        cfg_irrel_num = irrel;
        cfg_load      = 1'b1;
        step();
        cfg_load      = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    // Called one cycle after the start edge; ends one cycle after the su_add_finish pulse.
    task automatic expect_drain(input int rel, input logic acc, input logic bank,
                                input int poke, input logic [1:0] rel_end);
        chk("start_busy", 512'(busy), 512'(1));
        chk("fetch_wen", 512'(gbf_bus.psum_gbf_w_en), 512'(0));
        step();
        chk("fetch_wen2", 512'(gbf_bus.psum_gbf_w_en), 512'(0));
        for (int r = 0; r < rel; r++) begin
            for (int k = 0; k < 8; k++) begin
                step();
                pe_psum_finish = 1'b0;
                conv_finish    = 1'b0;
                chk("beat_wen", 512'(gbf_bus.psum_gbf_w_en), 512'(1));
                chk("beat_addr", 512'(gbf_bus.psum_gbf_w_addr), 512'(r * 8 + k));
                chk("beat_data", gbf_bus.out_data, chunk(r, k));
                chk("beat_acc", 512'(gbf_bus.psum_gbf_w_acc), 512'(acc));
                chk("beat_bank", 512'(gbf_bus.psum_gbf_w_num), 512'(bank));
                if (r == 0 && k == poke) begin
                    pe_psum_finish = 1'b1;
                    conv_finish    = 1'b1;
                end
            end
            if (r < rel - 1) begin
                step();
                chk("bubble_wen", 512'(gbf_bus.psum_gbf_w_en), 512'(0));
            end
        end
        chk("last_beat_su_low", 512'(su_add_finish), 512'(0));
        gbf_bus.buf_release = rel_end;
        step();
        gbf_bus.buf_release = 2'b00;
        chk("su_pulse", 512'(su_add_finish), 512'(1));
        chk("end_busy", 512'(busy), 512'(0));
        chk("end_wen", 512'(gbf_bus.psum_gbf_w_en), 512'(0));
        step();
        chk("su_one_shot", 512'(su_add_finish), 512'(0));
    endtask

    initial begin
        reset_n             = 1'b0;
        cfg_load            = 1'b0;
        cfg_rel_num         = 3'd0;
        cfg_irrel_num       = 8'd0;
        pe_psum_finish      = 1'b0;
        conv_finish         = 1'b0;
        gbf_bus.buf_release = 2'b00;
        #1;
        chk("rst_wen", 512'(gbf_bus.psum_gbf_w_en), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_full", 512'(gbf_bus.buf_full), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_err", 512'(err_overrun), 512'(0));
        chk("rst_su", 512'(su_add_finish), 512'(0));
        chk("rst_rfaddr", 512'(psum_rf_addr), 512'(0));
        chk("rst_wnum", 512'(gbf_bus.psum_gbf_w_num), 512'(0));
        repeat (2) step();
        reset_n = 1'b1;
        step();

        // one event of 4 slices, single pass per bank
        load_cfg(3'd4, 8'd1);
        pulse_start();
        expect_drain(4, 1'b0, 1'b0, -1, 2'b00);
        chk("t1_full", 512'(gbf_bus.buf_full), 512'(2'b01));
        chk("t1_wnum", 512'(gbf_bus.psum_gbf_w_num), 512'(1));
        chk("t1_err", 512'(err_overrun), 512'(0));

        // three accumulated passes; a mid-bank cfg_load must be ignored
        do_reset();
        load_cfg(3'd2, 8'd3);
        pulse_start();
        expect_drain(2, 1'b0, 1'b0, -1, 2'b00);
        chk("t2_full_a", 512'(gbf_bus.buf_full), 512'(2'b00));
        load_cfg(3'd1, 8'd1);
        pulse_start();
        expect_drain(2, 1'b1, 1'b0, -1, 2'b00);
        chk("t2_full_b", 512'(gbf_bus.buf_full), 512'(2'b00));
        pulse_start();
        expect_drain(2, 1'b1, 1'b0, -1, 2'b00);
        chk("t2_full_c", 512'(gbf_bus.buf_full), 512'(2'b01));
        chk("t2_wnum", 512'(gbf_bus.psum_gbf_w_num), 512'(1));

        // both banks full: wait, then release bank 0
        do_reset();
        pulse_start();
        expect_drain(1, 1'b0, 1'b0, -1, 2'b00);
        pulse_start();
        expect_drain(1, 1'b0, 1'b1, -1, 2'b00);
        chk("t3_full_both", 512'(gbf_bus.buf_full), 512'(2'b11));
        chk("t3_wnum", 512'(gbf_bus.psum_gbf_w_num), 512'(0));
        pulse_start();
        chk("t3_wait_busy", 512'(busy), 512'(1));
        repeat (3) step();
        chk("t3_wait_wen", 512'(gbf_bus.psum_gbf_w_en), 512'(0));
        chk("t3_wait_busy2", 512'(busy), 512'(1));
        gbf_bus.buf_release = 2'b01;
        step();
        gbf_bus.buf_release = 2'b00;
        chk("t3_released", 512'(gbf_bus.buf_full), 512'(2'b10));
        expect_drain(1, 1'b0, 1'b0, -1, 2'b00);
        chk("t3_full_end", 512'(gbf_bus.buf_full), 512'(2'b11));

        // overrun and conv_finish mid-event, partial bank flushed at DONE
        do_reset();
        load_cfg(3'd1, 8'd3);
        pulse_start();
        expect_drain(1, 1'b0, 1'b0, 2, 2'b00);
        chk("t4_done", 512'(done), 512'(1));
        chk("t4_err", 512'(err_overrun), 512'(1));
        chk("t4_full", 512'(gbf_bus.buf_full), 512'(2'b01));
        chk("t4_wnum", 512'(gbf_bus.psum_gbf_w_num), 512'(1));
        pulse_start();
        step();
        chk("t4_ignored_busy", 512'(busy), 512'(0));
        chk("t4_ignored_wen", 512'(gbf_bus.psum_gbf_w_en), 512'(0));
        chk("t4_done_sticky", 512'(done), 512'(1));

        // asynchronous reset in the middle of the second slice
        do_reset();
        load_cfg(3'd2, 8'd1);
        pulse_start();
        expect_drain(2, 1'b0, 1'b0, -1, 2'b00);
        chk("t5_full_pre", 512'(gbf_bus.buf_full), 512'(2'b01));
        pulse_start();
        repeat (14) step();
        chk("t5_mid_addr", 512'(gbf_bus.psum_gbf_w_addr), 512'(11));
        chk("t5_mid_rfaddr", 512'(psum_rf_addr), 512'(1));
        reset_n = 1'b0;
        #1;
        chk("t5_rst_wen", 512'(gbf_bus.psum_gbf_w_en), 512'(0));
        chk("t5_rst_busy", 512'(busy), 512'(0));
        chk("t5_rst_full", 512'(gbf_bus.buf_full), 512'(0));
        chk("t5_rst_rfaddr", 512'(psum_rf_addr), 512'(0));
        repeat (2) step();
        reset_n = 1'b1;
        step();
        pulse_start();
        expect_drain(1, 1'b0, 1'b0, -1, 2'b00);
        chk("t5_full_post", 512'(gbf_bus.buf_full), 512'(2'b01));

        // zero cfg stored as 1; release in the same cycle as the set loses
        do_reset();
        load_cfg(3'd0, 8'd0);
        pulse_start();
        expect_drain(1, 1'b0, 1'b0, -1, 2'b01);
        chk("t6_set_wins", 512'(gbf_bus.buf_full), 512'(2'b01));
        chk("t6_wnum", 512'(gbf_bus.psum_gbf_w_num), 512'(1));
        gbf_bus.buf_release = 2'b01;
        step();
        gbf_bus.buf_release = 2'b00;
        chk("t6_release", 512'(gbf_bus.buf_full), 512'(2'b00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
